// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: synchronizes a raw button, waits for a stable level and emits
// one enable_out pulse per accepted press. Define BTN_DEBOUNCE_AUTOREPEAT_EN to enable auto-repeat.
module btn_debounce_pulse #(
  parameter int CLK_DIV      = 50000,
  parameter int STABLE_COUNT = 10,
  parameter int REPEAT_TICKS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic enable_out
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = $clog2(STABLE_COUNT + 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("btn_debounce_pulse: CLK_DIV must be >= 2");
  end
  if (STABLE_COUNT < 1) begin : g_bad_stable_count
    $error("btn_debounce_pulse: STABLE_COUNT must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat_ticks
    $error("btn_debounce_pulse: REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [1:0]    sync_q, sync_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] stab_q, stab_d;
  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic          btn_s;
  logic          tick;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  assign btn_s      = sync_q[1];
  assign tick       = (pre_q == PW'(CLK_DIV - 1));
  assign enable_out = enable_q;

  always_comb begin
    sync_d   = {sync_q[0], btn_in};
    pre_d    = tick ? '0 : pre_q + 1'b1;
    stab_d   = (tick && (stab_q != SW'(STABLE_COUNT))) ? stab_q + 1'b1 : stab_q;
    state_d  = state_q;
    enable_d = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    rep_d    = rep_q;
`endif

    // A btn_s change is tested before tick so it wins when both occur together.
    case (state_q)
      IDLE: begin
        if (btn_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (tick && (stab_q == SW'(STABLE_COUNT - 1))) begin
          state_d  = PRESSED;
          enable_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
        end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        else if (tick) begin
          if (rep_q == RW'(REPEAT_TICKS - 1)) begin
            enable_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (tick && (stab_q == SW'(STABLE_COUNT - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restarting the prescaler on entry makes the acceptance latency cycle-exact.
    if (state_d != state_q) begin
      stab_d = '0;
      if (state_d != IDLE) pre_d = '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      if (state_d == PRESSED) rep_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      pre_q    <= '0;
      stab_q   <= '0;
      state_q  <= IDLE;
      enable_q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      sync_q   <= sync_d;
      pre_q    <= pre_d;
      stab_q   <= stab_d;
      state_q  <= state_d;
      enable_q <= enable_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

endmodule
